// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, per-button debounce counter and a
// hold/auto-repeat FSM, producing a debounced level plus registered event pulses.
module button_debouncer #(
  parameter int NBTNS           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBTNS-1:0] i_btn,
  output logic [NBTNS-1:0] o_btn,
  output logic [NBTNS-1:0] o_press,
  output logic [NBTNS-1:0] o_release,
  output logic [NBTNS-1:0] o_hold,
  output logic             o_int
);

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [DW-1:0] DTERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HTERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RTERM = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_REPEAT} state_t;

  logic [NBTNS-1:0] s1_q, s2_q;
  logic [NBTNS-1:0] btn_q, btn_d;
  logic [NBTNS-1:0] press_q, press_d;
  logic [NBTNS-1:0] release_q, release_d;
  logic [NBTNS-1:0] hold_q, hold_d;
  logic             int_q, int_d;
  logic [DW-1:0]    dcnt_q  [NBTNS];
  logic [DW-1:0]    dcnt_d  [NBTNS];
  logic [HW-1:0]    hcnt_q  [NBTNS];
  logic [HW-1:0]    hcnt_d  [NBTNS];
  state_t           state_q [NBTNS];
  state_t           state_d [NBTNS];

  always_comb begin
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    int_d     = |(press_q | release_q | hold_q);
    for (int k = 0; k < NBTNS; k++) begin
      dcnt_d[k]  = dcnt_q[k];
      hcnt_d[k]  = hcnt_q[k];
      state_d[k] = state_q[k];

      if (s2_q[k] == btn_q[k]) begin
        dcnt_d[k] = '0;
      end else if (dcnt_q[k] == DTERM) begin
        btn_d[k]     = s2_q[k];
        dcnt_d[k]    = '0;
        press_d[k]   = s2_q[k];
        release_d[k] = ~s2_q[k];
      end else begin
        dcnt_d[k] = dcnt_q[k] + DW'(1);
      end

      // A debounced fall always wins over a hold tick landing on the same edge.
      case (state_q[k])
        ST_UP: begin
          if (press_d[k]) begin
            state_d[k] = ST_DOWN;
            hcnt_d[k]  = '0;
          end
        end
        ST_DOWN: begin
          if (release_d[k]) begin
            state_d[k] = ST_UP;
            hcnt_d[k]  = '0;
          end else if (hcnt_q[k] == HTERM) begin
            hold_d[k]  = 1'b1;
            state_d[k] = ST_REPEAT;
            hcnt_d[k]  = '0;
          end else begin
            hcnt_d[k] = hcnt_q[k] + HW'(1);
          end
        end
        ST_REPEAT: begin
          if (release_d[k]) begin
            state_d[k] = ST_UP;
            hcnt_d[k]  = '0;
          end else if (hcnt_q[k] == RTERM) begin
            hold_d[k] = 1'b1;
            hcnt_d[k] = '0;
          end else begin
            hcnt_d[k] = hcnt_q[k] + HW'(1);
          end
        end
        default: begin
          state_d[k] = ST_UP;
          hcnt_d[k]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      int_q     <= 1'b0;
      for (int k = 0; k < NBTNS; k++) begin
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
        state_q[k] <= ST_UP;
      end
    end else begin
      s1_q      <= i_btn;
      s2_q      <= s1_q;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      int_q     <= int_d;
      for (int k = 0; k < NBTNS; k++) begin
        dcnt_q[k]  <= dcnt_d[k];
        hcnt_q[k]  <= hcnt_d[k];
        state_q[k] <= state_d[k];
      end
    end
  end

  assign o_btn     = btn_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_hold    = hold_q;
  assign o_int     = int_q;

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Input-side counterpart to the board's LED driver: conditions the raw push-button inputs on the same board. Each button is synchronized and debounced, and the block emits a debounced level plus single-cycle press, release and long-press/auto-repeat event pulses. It sits between the button pads and the bus-visible control logic. The registered `o_int` output feeds the interrupt controller.

## Interface

Parameters:
- `NBTNS`, 5: number of buttons, at least 1.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronized input must differ from the debounced level before the level is accepted (10 ms at 100 MHz). At least 1.
- `HOLD_CYCLES`, 50_000_000: cycles after the press pulse until the first `o_hold` pulse. At least 1.
- `REPEAT_CYCLES`, 10_000_000: cycles between auto-repeat `o_hold` pulses. At least 1.

Ports:
- `i_clk`, in, 1: system clock. All logic runs on its rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_btn`, in, NBTNS: raw, asynchronous button pins, 1 = pressed.
- `o_btn`, out, NBTNS: debounced button level.
- `o_press`, out, NBTNS: one-cycle pulse when `o_btn[k]` rises.
- `o_release`, out, NBTNS: one-cycle pulse when `o_btn[k]` falls.
- `o_hold`, out, NBTNS: one-cycle pulse on long press, then at the auto-repeat rate while the button is held.
- `o_int`, out, 1: registered OR of all event pulses, delayed one cycle.

## Operation

- Each button is processed independently. Events on different buttons in the same cycle are all reported.
- **Synchronizer:** two flip-flops per bit (`s1`, `s2`), both reset to 0. Only `s2` is used downstream.
- **Debounce counter:** `dcnt[k]`, sized to hold `DEBOUNCE_CYCLES-1`.
  - If `s2 == o_btn`, then `dcnt` goes to 0.
  - Else, if `dcnt == DEBOUNCE_CYCLES-1`, then `o_btn` becomes `s2`, `dcnt` goes to 0, and `o_press` or `o_release` pulses on the same edge.
  - Else, `dcnt` increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` consecutive cycles never changes `o_btn`.
- **Hold FSM per button:** states UP, DOWN and REPEAT, with hold counter `hcnt` sized for `max(HOLD, REPEAT)-1`.
  - UP: on a debounced rise, go to DOWN with `hcnt` = 0.
  - DOWN: if `hcnt == HOLD_CYCLES-1`, pulse `o_hold`, go to REPEAT, and set `hcnt` = 0. Otherwise increment `hcnt`.
  - REPEAT: if `hcnt == REPEAT_CYCLES-1`, pulse `o_hold` and set `hcnt` = 0. Otherwise increment `hcnt`.
  - DOWN or REPEAT: on a debounced fall, pulse `o_release`, go to UP, and set `hcnt` = 0. A fall takes priority: no `o_hold` pulse on the same edge.
- **Counter arithmetic:** all counters use unsigned compare-to-terminal and clear. They never wrap past their terminal value.

## Timing

- **Reset values:** on the edge where `i_reset` is high, all state clears.
  - Synchronizers, `dcnt`, `hcnt`, `o_btn`, `o_press`, `o_release`, `o_hold` and `o_int` all go to 0.
  - The FSM goes to UP.
  - No pulse is emitted on the first edge after reset is released.
- **Debounce latency:** `i_btn` changes and then stays stable. Count the first edge that samples the new value as edge 1. `o_btn`, together with the `o_press` or `o_release` pulse, updates on edge `DEBOUNCE_CYCLES+2`.
- **Hold timing:** if the press pulse is on edge P, the first `o_hold` is on edge P+HOLD_CYCLES. Repeats follow at P+HOLD_CYCLES+n·REPEAT_CYCLES.
- **Interrupt:** `o_int` is high on the edge after any bit of `o_press`, `o_release` or `o_hold` was high.
- **Reset mid-operation:** a partially counted bounce or hold is discarded. If the button is still held after reset, it is re-detected as a new press after the full debounce latency.
- **Parameter value 1:**
  - `DEBOUNCE_CYCLES=1` gives a latency of 3 edges.
  - `HOLD_CYCLES=1` gives `o_hold` on the edge after the press.
  - `REPEAT_CYCLES=1` gives `o_hold` asserted every cycle while in REPEAT.
- All event outputs are registered, with no combinational path from `i_btn`.

## Test plan

Parameters for every scenario: NBTNS=2, DEBOUNCE=4, HOLD=20, REPEAT=8.

1. **Reset:** hold `i_btn=2'b11` through reset and release at cycle 0. Required: all outputs 0 during reset. `o_btn=2'b11` with `o_press=2'b11` on edge 6 only. `o_int` is 1 on edge 7.
2. **Bounce rejection:** toggle `i_btn[0]` high for 3 cycles, low for 1, high for 3, then low. Required: `o_btn[0]` stays 0 and no pulses occur. A following stable 6-cycle high produces `o_press[0]` on edge 6 of that high.
3. **Long press and repeat:** hold `i_btn[1]` for 60 cycles. Required:
   - `o_press[1]` at edge P.
   - `o_hold[1]` at P+20, P+28, P+36 and so on, each exactly one cycle wide.
   - `o_release[1]` at edge 6 after `i_btn` falls.
4. **Release priority:** time the debounced fall to land on edge P+20. Required: `o_release=1`, `o_hold=0` on that edge, and the FSM returns to UP.
5. **Simultaneous buttons:** raise both bits in the same cycle, then drop bit 0 only. Required: both bits of `o_press` on the same edge, and later `o_release=2'b01` with `o_btn=2'b10`.
6. **Reset mid-hold:** assert `i_reset` for 1 cycle at P+15 with the button still held. Required: no `o_hold` at P+20, and a new `o_press` 6 edges after reset is released.
